// File: rtl/seq_signed_divider_pkg.sv
// Shared control constants for the sequential arithmetic units (divider, Booth multiplier):
// state encoding, state width, iteration-counter width and the divider result tags.
package seq_signed_divider_pkg;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] S_FIX  = 2'd2;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int L_WORD_DEF = 4;
  localparam int CNT_W_DEF  = cnt_w(L_WORD_DEF);

  // Why S_FIX was entered: normal completion or one of the short-circuit results.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DIV0 = 2'd1,
    TAG_OVF  = 2'd2
  } tag_e;

endpackage

// File: rtl/div_datapath_unit.sv
// Datapath of the signed divider: magnitude capture, restoring shift-subtract, sign fix and
// result registers. SEQ_DIVIDER_EARLY_EXIT_EN lets a zero dividend bypass the iterations.
module div_datapath_unit
  import seq_signed_divider_pkg::*;
#(
  parameter int l_word = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  fix_i,
  input  tag_e                  tag_i,
  input  logic [2*l_word-1:0]   dividend_i,
  input  logic [l_word-1:0]     divisor_i,
  output logic                  div0_o,
  output logic                  early_ovf_o,
  output logic                  zero_skip_o,
  output logic [l_word-1:0]     quotient_o,
  output logic [l_word-1:0]     remainder_o,
  output logic                  div_zero_o,
  output logic                  overflow_o
);

  localparam int L  = l_word;
  localparam int DW = 2 * l_word;
  localparam logic [L:0] Q_POS_MAX = (L+1)'((1 << (L - 1)) - 1);
  localparam logic [L:0] Q_NEG_MAX = (L+1)'(1 << (L - 1));

  logic [DW-1:0] dvd_mag;
  logic [L:0]    dsr_ext, dsr_mag;

  assign dvd_mag     = dividend_i[DW-1] ? (~dividend_i + DW'(1)) : dividend_i;
  assign dsr_ext     = {divisor_i[L-1], divisor_i};
  assign dsr_mag     = divisor_i[L-1] ? (~dsr_ext + (L+1)'(1)) : dsr_ext;
  assign div0_o      = (divisor_i == '0);
  // Upper half already >= divisor means the quotient magnitude needs more than l_word bits.
  assign early_ovf_o = ({1'b0, dvd_mag[DW-1:L]} >= dsr_mag);
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
  assign zero_skip_o = (dividend_i == '0);
`else
  assign zero_skip_o = 1'b0;
`endif

  logic [DW-1:0]  rq_q, rq_d;
  logic [L:0]     dmag_q;
  logic           dvd_neg_q, q_neg_q;
  logic [L-1:0]   dvd_lo_q;
  logic [L-1:0]   quo_q, rem_q;
  logic           dz_q, ov_q;

  // One restoring step: upper l_word+1 bits of the shifted register against |divisor|.
  logic [L:0]     trial, diff;
  logic           ge;
  logic [DW-1:0]  step_rq;
  logic           unused_diff_msb;

  assign trial           = rq_q[DW-1:L-1];
  assign ge              = (trial >= dmag_q);
  assign diff            = trial - dmag_q;
  assign step_rq         = {(ge ? diff[L-1:0] : trial[L-1:0]), rq_q[L-2:0], ge};
  assign unused_diff_msb = diff[L];

  always_comb begin
    rq_d = rq_q;
    if (load_i)      rq_d = dvd_mag;
    else if (step_i) rq_d = step_rq;
  end

  logic [L-1:0] qmag, rmag, q_fix, r_fix;
  logic         q_fits;

  assign qmag   = rq_q[L-1:0];
  assign rmag   = rq_q[DW-1:L];
  assign q_fix  = q_neg_q   ? (~qmag + L'(1)) : qmag;
  assign r_fix  = dvd_neg_q ? (~rmag + L'(1)) : rmag;
  assign q_fits = q_neg_q ? ({1'b0, qmag} <= Q_NEG_MAX) : ({1'b0, qmag} <= Q_POS_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      rq_q      <= '0;
      dmag_q    <= '0;
      dvd_neg_q <= 1'b0;
      q_neg_q   <= 1'b0;
      dvd_lo_q  <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dz_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      rq_q <= rq_d;
      if (load_i) begin
        dmag_q    <= dsr_mag;
        dvd_neg_q <= dividend_i[DW-1];
        q_neg_q   <= dividend_i[DW-1] ^ divisor_i[L-1];
        dvd_lo_q  <= dividend_i[L-1:0];
      end
      if (fix_i) begin
        case (tag_i)
          TAG_DIV0: begin
            quo_q <= '1;
            rem_q <= dvd_lo_q;
            dz_q  <= 1'b1;
            ov_q  <= 1'b0;
          end
          TAG_NONE: begin
            quo_q <= q_fits ? q_fix : '0;
            rem_q <= q_fits ? r_fix : '0;
            dz_q  <= 1'b0;
            ov_q  <= ~q_fits;
          end
          default: begin
            quo_q <= '0;
            rem_q <= '0;
            dz_q  <= 1'b0;
            ov_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign div_zero_o  = dz_q;
  assign overflow_o  = ov_q;

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider (2*l_word / l_word) with start/ready handshake and done pulse.
// Build option SEQ_DIVIDER_EARLY_EXIT_EN: zero dividend finishes in 2 cycles instead of l_word+2.
module seq_signed_divider
  import seq_signed_divider_pkg::*;
#(
  parameter int l_word = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [2*l_word-1:0] dividend,
  input  logic [l_word-1:0]   divisor,
  output logic [l_word-1:0]   quotient,
  output logic [l_word-1:0]   remainder,
  output logic                ready,
  output logic                done,
  output logic                div_zero,
  output logic                overflow
);

  localparam int CW = cnt_w(l_word);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  tag_e               tag_q, tag_d;
  logic               done_q, done_d;
  logic               load, step, fix;
  logic               div0, early_ovf, zero_skip;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load  = 1'b1;
          cnt_d = CW'(l_word);
          if (div0) begin
            tag_d   = TAG_DIV0;
            state_d = S_FIX;
          end else if (early_ovf) begin
            tag_d   = TAG_OVF;
            state_d = S_FIX;
          end else begin
            tag_d   = TAG_NONE;
            state_d = zero_skip ? S_FIX : S_RUN;
          end
        end
      end
      S_RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        fix     = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tag_q   <= TAG_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = done_q;

  div_datapath_unit #(.l_word(l_word)) u_dp (
    .clock       (clock),
    .reset       (reset),
    .load_i      (load),
    .step_i      (step),
    .fix_i       (fix),
    .tag_i       (tag_q),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .div0_o      (div0),
    .early_ovf_o (early_ovf),
    .zero_skip_o (zero_skip),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .div_zero_o  (div_zero),
    .overflow_o  (overflow)
  );

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider (l_word=4): directed table, handshake/reset sequences, random vs model.
module tb_seq_signed_divider;

  localparam int L = 4;
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = L + 2;
`endif

  logic         clock = 1'b0;
  logic         reset, start;
  logic [7:0]   dividend;
  logic [3:0]   divisor, quotient, remainder;
  logic         ready, done, div_zero, overflow;
  int           n_vec = 0;
  int           n_err = 0;

  seq_signed_divider #(.l_word(L)) dut (
    .clock(clock), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .ready(ready), .done(done),
    .div_zero(div_zero), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dsr;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ov;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer division, result range rules, latency classes.
  function automatic void model(input logic [7:0] dvd, input logic [3:0] dsr,
                                output logic [3:0] q, output logic [3:0] r,
                                output logic dz, output logic ov, output int lat);
    int a, b, qt, rt, aa, ab;
    a  = int'($signed(dvd));
    b  = int'($signed(dsr));
    aa = (a < 0) ? -a : a;
    ab = (b < 0) ? -b : b;
    dz = 1'b0;
    ov = 1'b0;
    lat = L + 2;
    if (b == 0) begin
      q = 4'hF; r = dvd[3:0]; dz = 1'b1; lat = 2;
    end else begin
      qt = a / b;
      rt = a % b;
      if (qt > 7 || qt < -8) begin
        ov = 1'b1; q = 4'h0; r = 4'h0;
      end else begin
        q = qt[3:0]; r = rt[3:0];
      end
      if (aa >= 16 * ab) lat = 2;
      if (a == 0) lat = ZLAT;
    end
  endfunction

  task automatic run_op(input logic [7:0] dvd, input logic [3:0] dsr,
                        output logic [3:0] q, output logic [3:0] r,
                        output logic dz, output logic ov, output int lat);
    @(negedge clock);
    dividend = dvd;
    divisor  = dsr;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    q = quotient; r = remainder; dz = div_zero; ov = overflow;
  endtask

  task automatic apply(input string tag, input vec_t v);
    logic [3:0] q, r;
    logic       dz, ov;
    int         lat;
    run_op(v.dvd, v.dsr, q, r, dz, ov, lat);
    chk({tag, " quotient"},  32'(q),   32'(v.q));
    chk({tag, " remainder"}, 32'(r),   32'(v.r));
    chk({tag, " div_zero"},  32'(dz),  32'(v.dz));
    chk({tag, " overflow"},  32'(ov),  32'(v.ov));
    chk({tag, " latency"},   32'(lat), 32'(v.lat));
  endtask

  vec_t tbl[10];

  initial begin
    vec_t       v;
    logic [3:0] q, r;
    logic       dz, ov;
    int         lat, pulses, first_lat;
    logic [3:0] fq, fr;
    logic [4:0] s5;

    tbl[0] = '{8'h14, 4'h3, 4'h6, 4'h2, 1'b0, 1'b0, 6};
    tbl[1] = '{8'hEC, 4'h3, 4'hA, 4'hE, 1'b0, 1'b0, 6};
    tbl[2] = '{8'h14, 4'hD, 4'hA, 4'h2, 1'b0, 1'b0, 6};
    tbl[3] = '{8'hF0, 4'h2, 4'h8, 4'h0, 1'b0, 1'b0, 6};
    tbl[4] = '{8'h10, 4'h2, 4'h0, 4'h0, 1'b0, 1'b1, 6};
    tbl[5] = '{8'h35, 4'h0, 4'hF, 4'h5, 1'b1, 1'b0, 2};
    tbl[6] = '{8'h00, 4'h5, 4'h0, 4'h0, 1'b0, 1'b0, ZLAT};
    tbl[7] = '{8'h80, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2};
    tbl[8] = '{8'h7F, 4'h8, 4'h0, 4'h0, 1'b0, 1'b1, 6};
    tbl[9] = '{8'hFF, 4'h1, 4'hF, 4'h0, 1'b0, 1'b0, 6};

    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset done",  32'(done),  32'd0);
    chk("reset outs",  32'({quotient, remainder, div_zero, overflow}), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) apply($sformatf("tbl[%0d]", i), tbl[i]);

    // Second start during S_RUN is ignored; exactly one done with the first result.
    @(negedge clock);
    dividend = 8'h14; divisor = 4'h3; start = 1'b1;
    @(posedge clock);
    #1;
    chk("busy ready", 32'(ready), 32'd0);
    dividend = 8'h35; divisor = 4'h0;
    pulses = 0; first_lat = 0; fq = '0; fr = '0;
    for (int k = 2; k <= 12; k++) begin
      @(posedge clock);
      #1;
      if (k == 3) start = 1'b0;
      if (done) begin
        pulses++;
        if (pulses == 1) begin first_lat = k; fq = quotient; fr = remainder; end
      end
    end
    chk("hs pulses",   32'(pulses),    32'd1);
    chk("hs latency",  32'(first_lat), 32'd6);
    chk("hs quotient", 32'(fq),        32'h6);
    chk("hs remainder",32'(fr),        32'h2);

    // Leave nonzero outputs/flags, then reset in the middle of S_RUN.
    v = '{8'h35, 4'h0, 4'hF, 4'h5, 1'b1, 1'b0, 2};
    apply("pre-reset div0", v);
    @(negedge clock);
    dividend = 8'h14; divisor = 4'h3; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("midrst ready", 32'(ready), 32'd1);
    chk("midrst done",  32'(done),  32'd0);
    chk("midrst outs",  32'({quotient, remainder, div_zero, overflow}), 32'd0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      if (done) pulses++;
    end
    chk("midrst no done", 32'(pulses), 32'd0);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 2))
        0: v.dvd = 8'($urandom);
        1: begin s5 = 5'($urandom); v.dvd = {{3{s5[4]}}, s5}; end
        default: v.dvd = (i % 7 == 0) ? 8'h00 : 8'($urandom_range(0, 40));
      endcase
      v.dsr = 4'($urandom);
      model(v.dvd, v.dsr, v.q, v.r, v.dz, v.ov, v.lat);
      apply($sformatf("rnd %0d (%02h/%01h)", i, v.dvd, v.dsr), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Multi-cycle signed two's-complement divider; the inverse companion to the sequential Booth multiplier.
- Takes a 2*l_word-bit dividend (e.g. a product) and an l_word-bit divisor.
- Returns an l_word-bit quotient and an l_word-bit remainder using restoring shift-subtract on magnitudes.
- Sits beside the multiplier in the arithmetic datapath and uses the same start/ready handshake style.

Parameters:
- l_word, 4, operand width; dividend is 2*l_word bits, quotient and remainder are l_word bits each.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- dividend  input  2*l_word  signed dividend; captured on accepted start.
- divisor  input  l_word  signed divisor; captured on accepted start.
- quotient  output  l_word  signed quotient; truncated toward zero.
- remainder  output  l_word  signed remainder; takes the sign of the dividend.
- ready  output  1  high in S_IDLE; a new start is accepted only then.
- done  output  1  one-cycle pulse when quotient/remainder/flags are updated.
- div_zero  output  1  the last operation had divisor==0.
- overflow  output  1  the last quotient did not fit in signed l_word.

Behaviour:
- Reset (synchronous, active-high): state=S_IDLE; quotient, remainder, done, div_zero and overflow all 0; ready=1.
- Reset mid-operation aborts the operation with no done pulse.
- States: S_IDLE, S_RUN, S_FIX.
- S_IDLE, start=1:
  - Capture the sign of dividend and the sign of the quotient (dividend sign XOR divisor sign).
  - Load |dividend| (2*l_word bits, unsigned) into the partial-remainder/quotient shift register; load |divisor| (l_word+1 bits, unsigned).
  - Load an iteration counter with l_word.
  - If divisor==0: go to S_FIX with an error tag.
  - Else if the upper l_word bits of |dividend| >= |divisor|: go to S_FIX with an overflow tag.
  - Else: go to S_RUN.
- S_RUN, one iteration per cycle:
  - Shift left by 1.
  - Trial-subtract |divisor| from the upper l_word+1 bits.
  - If the result is non-negative, keep it and shift in 1; otherwise restore and shift in 0.
  - Decrement the counter; go to S_FIX after l_word iterations.
- S_FIX:
  - Apply sign: quotient is negated if the signs differ; remainder is negated if the dividend was negative.
  - Range check on the quotient magnitude: positive result ≤ 2^(l_word-1)-1; negative result ≤ 2^(l_word-1). Violation sets overflow.
  - Register outputs, pulse done, return to S_IDLE.
- Error outputs:
  - div_zero: quotient = all ones, remainder = dividend[l_word-1:0], overflow=0.
  - overflow: quotient=0, remainder=0, div_zero=0.
- Latency from start to done:
  - Normal: l_word+2 cycles.
  - div_zero / early overflow: 2 cycles.
  - ready returns high the cycle done is asserted.
- Outputs and flags hold until the next done or reset.
- start while ready=0 is ignored; the operand inputs need not be held after acceptance.
- Internal arithmetic is l_word+1 bits wide to avoid losing the carry on the trial subtract.

Optional Feature:
- Macro: SEQ_DIVIDER_EARLY_EXIT_EN.
- Defined: a dividend of 0 with a nonzero divisor skips S_RUN; go directly to S_FIX with quotient=0 and remainder=0 (latency 2 cycles).
- Undefined: a zero dividend runs the full l_word iterations with the same result.
- divisor==0 handling is identical in both builds.

Decomposition:
- Shared package: state encoding constants (S_IDLE=0, S_RUN=1, S_FIX=2), state width, and a counter-width constant ($clog2(l_word+1)), reusable by the multiplier's control.
- Natural split: the control FSM is kept inline; one sub-module, div_datapath_unit, holds the shift register, trial subtractor, and sign fix.

Test Plan (l_word=4):
- 20 / 3: dividend=8'h14, divisor=4'h3 -> after 6 cycles done=1, quotient=4'h6, remainder=4'h2, flags 0.
- -20 / 3 and 20 / -3: dividend=8'hEC with divisor 3 -> quotient=4'hA (-6), remainder=4'hE (-2); dividend=8'h14 with divisor=4'hD -> quotient=4'hA, remainder=4'h2.
- Range limits: dividend=8'hF0 (-16), divisor=2 -> quotient=4'h8 (-8), overflow=0; dividend=8'h10, divisor=2 -> overflow=1, quotient=0.
- Divide by zero: divisor=0, dividend=8'h35 -> done after 2 cycles, div_zero=1, quotient=4'hF, remainder=4'h5.
- Handshake: pulse start again during S_RUN with different operands -> ignored; single done with the first result. Assert reset mid-S_RUN -> ready=1 next cycle, outputs 0, no done pulse.
- Zero dividend: dividend=0, divisor=5 -> quotient=0, remainder=0; latency 2 cycles with SEQ_DIVIDER_EARLY_EXIT_EN, 6 cycles without.
